// File: rtl/pipeline_stage_channel.sv
// pipeline_stage_channel: elastic {ctrl,data} FIFO link between pipeline stages; axis_s_* in, axis_m_*/ctrl_data_o out, level/almost_full status, flush squashes all entries
module pipeline_stage_channel #(
  parameter int DATA_WIDTH  = 32,
  parameter int CTRL_WIDTH  = 16,
  parameter int DEPTH       = 2,
  parameter int AFULL_LEVEL = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         axis_s_data_tvalid,
  output logic                         axis_s_data_tready,
  input  logic [DATA_WIDTH-1:0]        axis_s_data_tdata,
  input  logic [CTRL_WIDTH-1:0]        ctrl_data_i,
  output logic                         axis_m_data_tvalid,
  input  logic                         axis_m_data_tready,
  output logic [DATA_WIDTH-1:0]        axis_m_data_tdata,
  output logic [CTRL_WIDTH-1:0]        ctrl_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         almost_full
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  logic [DATA_WIDTH+CTRL_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic af_q, push, pop;
  assign axis_s_data_tready = !rst && cnt_q != LW'(DEPTH);
  assign axis_m_data_tvalid = cnt_q != '0;
  assign push = axis_s_data_tvalid && axis_s_data_tready;
  assign pop = axis_m_data_tvalid && axis_m_data_tready;
  assign {ctrl_data_o, axis_m_data_tdata} = axis_m_data_tvalid ? mem_q[rd_q] : '0;
  assign level = cnt_q;
  assign almost_full = af_q;
  always_comb begin
    wr_d = !push ? wr_q : wr_q == PW'(DEPTH - 1) ? '0 : wr_q + 1'b1;
    rd_d = !pop ? rd_q : rd_q == PW'(DEPTH - 1) ? '0 : rd_q + 1'b1;
    cnt_d = cnt_q + LW'(push) - LW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      af_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      af_q <= cnt_d >= LW'(AFULL_LEVEL);
    end
  end
  always_ff @(posedge clk)
    if (push && !flush) mem_q[wr_q] <= {ctrl_data_i, axis_s_data_tdata};
endmodule
